// File: rtl/elastic_buffer_skp_scheduler_if.sv
// rtl/elastic_buffer_skp_scheduler_if.sv - symbol/pointer bundle between write path and SKP scheduler
interface elastic_buffer_skp_scheduler_if #(
    parameter int DATA_WIDTH = 10,
    parameter int PTR_W      = 5
);
    logic [DATA_WIDTH-1:0] data_in;
    logic [PTR_W-1:0]      gray_write_pointer;
    logic [PTR_W-1:0]      gray_read_pointer;
    logic                  skp_removed;
    logic                  delete_req;
    logic [PTR_W-1:0]      occupancy;
    logic                  high_flag;
    logic                  low_flag;
    logic                  os_err;
    logic [7:0]            delete_count;

    modport master (
        output data_in, gray_write_pointer, gray_read_pointer, skp_removed,
        input  delete_req, occupancy, high_flag, low_flag, os_err, delete_count
    );

    modport slave (
        input  data_in, gray_write_pointer, gray_read_pointer, skp_removed,
        output delete_req, occupancy, high_flag, low_flag, os_err, delete_count
    );
endinterface

// File: rtl/elastic_buffer_skp_scheduler.sv
// rtl/elastic_buffer_skp_scheduler.sv - write-domain occupancy tracking and SKP deletion scheduler
module elastic_buffer_skp_scheduler #(
    parameter int DATA_WIDTH   = 10,
    parameter int BUFFER_DEPTH = 16,
    parameter int HIGH_WM      = 12,
    parameter int LOW_WM       = 4,
    parameter int MAX_SKP      = 5
) (
    input  logic                          write_clk,
    input  logic                          rst_n,
    elastic_buffer_skp_scheduler_if.slave bus
);
    localparam int A  = $clog2(BUFFER_DEPTH);
    localparam int PW = A + 1;
    localparam int CW = $clog2(MAX_SKP + 1);

    localparam logic [DATA_WIDTH-1:0] COM_RDN = DATA_WIDTH'(10'b0011111010);
    localparam logic [DATA_WIDTH-1:0] COM_RDP = DATA_WIDTH'(10'b1100000101);
    localparam logic [DATA_WIDTH-1:0] SKP_RDN = DATA_WIDTH'(10'b0011111001);
    localparam logic [DATA_WIDTH-1:0] SKP_RDP = DATA_WIDTH'(10'b1100000110);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COM_SEEN = 2'd1,
        SKP_RUN  = 2'd2
    } state_t;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    state_t          state_q;
    logic [CW-1:0]   skp_in_os_q;
    logic            del_done_q;
    logic            os_err_q;
    logic [PW-1:0]   rgray_meta_q;
    logic [PW-1:0]   rgray_sync_q;
    logic [PW-1:0]   occupancy_q;
    logic [PW-1:0]   occupancy_d;
    logic            high_flag_q;
    logic            low_flag_q;
    logic [7:0]      delete_count_q;
    logic [PW-1:0]   wbin;
    logic [PW-1:0]   rbin_sync;
    logic            is_com;
    logic            is_skp;
    logic            delete_req;

    assign is_com = (bus.data_in == COM_RDN) || (bus.data_in == COM_RDP);
    assign is_skp = (bus.data_in == SKP_RDN) || (bus.data_in == SKP_RDP);

    assign wbin      = gray2bin(bus.gray_write_pointer);
    assign rbin_sync = gray2bin(rgray_sync_q);
    // The extra MSB makes a full buffer read BUFFER_DEPTH rather than wrap to 0.
    assign occupancy_d = wbin - rbin_sync;

    // Only SKPs inside an ordered set are candidates; COM can never match is_skp.
    assign delete_req = is_skp && (state_q != IDLE) && high_flag_q && !del_done_q;

    always_ff @(posedge write_clk or negedge rst_n) begin
        if (!rst_n) begin
            rgray_meta_q   <= '0;
            rgray_sync_q   <= '0;
            occupancy_q    <= '0;
            high_flag_q    <= 1'b0;
            low_flag_q     <= 1'b0;
            delete_count_q <= '0;
        end else begin
            rgray_meta_q <= bus.gray_read_pointer;
            rgray_sync_q <= rgray_meta_q;
            occupancy_q  <= occupancy_d;
            high_flag_q  <= occupancy_q >= PW'(HIGH_WM);
            low_flag_q   <= occupancy_q <= PW'(LOW_WM);
            if (bus.skp_removed && (delete_count_q != 8'hFF)) begin
                delete_count_q <= delete_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge write_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            skp_in_os_q <= '0;
            del_done_q  <= 1'b0;
            os_err_q    <= 1'b0;
        end else begin
            os_err_q <= 1'b0;
            if (delete_req) begin
                del_done_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (is_com) begin
                        state_q     <= COM_SEEN;
                        skp_in_os_q <= '0;
                        del_done_q  <= 1'b0;
                    end
                end
                COM_SEEN: begin
                    if (is_skp) begin
                        state_q     <= SKP_RUN;
                        skp_in_os_q <= CW'(1);
                    end else if (is_com) begin
                        skp_in_os_q <= '0;
                        del_done_q  <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SKP_RUN: begin
                    if (is_skp) begin
                        if (skp_in_os_q < CW'(MAX_SKP)) begin
                            skp_in_os_q <= skp_in_os_q + CW'(1);
                        end else begin
                            state_q  <= IDLE;
                            os_err_q <= 1'b1;
                        end
                    end else if (is_com) begin
                        state_q     <= COM_SEEN;
                        skp_in_os_q <= '0;
                        del_done_q  <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.delete_req   = delete_req;
    assign bus.occupancy    = occupancy_q;
    assign bus.high_flag    = high_flag_q;
    assign bus.low_flag     = low_flag_q;
    assign bus.os_err       = os_err_q;
    assign bus.delete_count = delete_count_q;
endmodule

// File: tb/tb_elastic_buffer_skp_scheduler.sv
// tb/tb_elastic_buffer_skp_scheduler.sv - directed bench with per-cycle reference model for the SKP scheduler
module tb_elastic_buffer_skp_scheduler;
    localparam int HIGH_WM = 12;
    localparam int LOW_WM  = 4;
    localparam int MAX_SKP = 5;

    localparam logic [9:0] COM  = 10'b0011111010;
    localparam logic [9:0] COMP = 10'b1100000101;
    localparam logic [9:0] SKP  = 10'b0011111001;
    localparam logic [9:0] SKPP = 10'b1100000110;
    localparam logic [9:0] DAT  = 10'b0101010101;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    elastic_buffer_skp_scheduler_if #(.DATA_WIDTH(10), .PTR_W(5)) ebi ();

    elastic_buffer_skp_scheduler #(
        .DATA_WIDTH(10), .BUFFER_DEPTH(16), .HIGH_WM(HIGH_WM), .LOW_WM(LOW_WM), .MAX_SKP(MAX_SKP)
    ) dut (
        .write_clk(clk),
        .rst_n    (rst_n),
        .bus      (ebi)
    );

    int vectors = 0;
    int miscompares = 0;
    int cur_w = 0;
    int cur_r = 0;
    logic del_seen;
    logic del_any;

    // Reference model: pipeline of read pointers, ordered-set bookkeeping
    int m_occ, m_rp0, m_rp1, m_cnt, m_n;
    logic m_high, m_low, m_err, m_open, m_deleted, m_del, m_err_nx;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] bin2gray(input int b);
        logic [4:0] x;
        x = b[4:0];
        return x ^ (x >> 1);
    endfunction

    function automatic logic sym_com(input logic [9:0] d);
        return (d == COM) || (d == COMP);
    endfunction

    function automatic logic sym_skp(input logic [9:0] d);
        return (d == SKP) || (d == SKPP);
    endfunction

    task automatic tick(input logic [9:0] d, input logic rem);
        ebi.data_in            = d;
        ebi.skp_removed        = rem;
        ebi.gray_write_pointer = bin2gray(cur_w);
        ebi.gray_read_pointer  = bin2gray(cur_r);
        #1 del_seen = ebi.delete_req;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            m_occ = 0; m_rp0 = 0; m_rp1 = 0; m_cnt = 0; m_n = 0;
            m_high = 0; m_low = 0; m_err = 0; m_open = 0; m_deleted = 0;
            chk("rst_delete_req", 32'(ebi.delete_req), 0);
            chk("rst_occupancy", 32'(ebi.occupancy), 0);
            chk("rst_high", 32'(ebi.high_flag), 0);
            chk("rst_low", 32'(ebi.low_flag), 0);
            chk("rst_os_err", 32'(ebi.os_err), 0);
            chk("rst_delete_count", 32'(ebi.delete_count), 0);
        end else begin
            m_del = sym_skp(ebi.data_in) && m_open && m_high && !m_deleted;
            chk("delete_req", 32'(ebi.delete_req), 32'(m_del));
            chk("occupancy", 32'(ebi.occupancy), m_occ);
            chk("high_flag", 32'(ebi.high_flag), 32'(m_high));
            chk("low_flag", 32'(ebi.low_flag), 32'(m_low));
            chk("os_err", 32'(ebi.os_err), 32'(m_err));
            chk("delete_count", 32'(ebi.delete_count), m_cnt);
            // advance to the state after the coming rising edge
            m_err_nx = 0;
            if (sym_com(ebi.data_in)) begin
                m_open = 1; m_n = 0; m_deleted = 0;
            end else if (sym_skp(ebi.data_in) && m_open) begin
                if (m_del) m_deleted = 1;
                m_n++;
                if (m_n > MAX_SKP) begin
                    m_open = 0;
                    m_err_nx = 1;
                end
            end else begin
                m_open = 0;
            end
            m_err = m_err_nx;
            if (ebi.skp_removed && m_cnt < 255) m_cnt++;
            m_high = (m_occ >= HIGH_WM);
            m_low  = (m_occ <= LOW_WM);
            m_occ  = (cur_w - m_rp1) & 31;
            m_rp1  = m_rp0;
            m_rp0  = cur_r;
        end
    end

    initial begin
        ebi.data_in = DAT;
        ebi.skp_removed = 1'b0;
        ebi.gray_write_pointer = '0;
        ebi.gray_read_pointer = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) tick(DAT, 0);
        chk("lit_rst_occ", 32'(ebi.occupancy), 0);
        chk("lit_rst_cnt", 32'(ebi.delete_count), 0);

        rst_n = 1'b1;
        tick(DAT, 0);
        chk("lit_low_after_first_clk", 32'(ebi.low_flag), 1);

        // fill to 13 with no read activity
        for (int w = 1; w <= 13; w++) begin
            cur_w = w;
            tick(DAT, 0);
        end
        repeat (4) tick(DAT, 0);
        chk("lit_occ13", 32'(ebi.occupancy), 13);
        chk("lit_high13", 32'(ebi.high_flag), 1);
        chk("lit_low13", 32'(ebi.low_flag), 0);

        // one delete on the first SKP of the ordered set
        tick(COM, 0); chk("lit_del_com", 32'(del_seen), 0);
        tick(SKP, 0); chk("lit_del_skp1", 32'(del_seen), 1);
        tick(SKP, 1); chk("lit_del_skp2", 32'(del_seen), 0);
        tick(SKP, 0); chk("lit_del_skp3", 32'(del_seen), 0);
        tick(DAT, 0);
        chk("lit_delete_count1", 32'(ebi.delete_count), 1);
        tick(SKP, 0); chk("lit_del_idle_skp", 32'(del_seen), 0);

        // occupancy 8: no deletion
        cur_r = 5;
        repeat (5) tick(DAT, 0);
        del_any = 0;
        tick(COM, 0);
        repeat (3) begin tick(SKP, 0); del_any |= del_seen; end
        chk("lit_del_occ8", 32'(del_any), 0);
        chk("lit_occ8", 32'(ebi.occupancy), 8);
        chk("lit_high8", 32'(ebi.high_flag), 0);
        chk("lit_low8", 32'(ebi.low_flag), 0);

        // MAX_SKP overrun
        tick(COM, 0);
        repeat (5) tick(SKP, 0);
        chk("lit_os_err_5", 32'(ebi.os_err), 0);
        tick(SKP, 0);
        chk("lit_os_err_6", 32'(ebi.os_err), 1);
        tick(DAT, 0);
        chk("lit_os_err_clear", 32'(ebi.os_err), 0);

        // occupancy 14: stray SKP, then back-to-back ordered sets
        cur_w = 19;
        repeat (5) tick(DAT, 0);
        tick(SKP, 0);  chk("lit_del_stray", 32'(del_seen), 0);
        tick(COMP, 0); chk("lit_del_b2b_com1", 32'(del_seen), 0);
        tick(SKPP, 0); chk("lit_del_b2b_skp1", 32'(del_seen), 1);
        tick(COM, 0);  chk("lit_del_b2b_com2", 32'(del_seen), 0);
        tick(SKP, 0);  chk("lit_del_b2b_skp2", 32'(del_seen), 1);

        // reset in the middle of an ordered set without a delete yet
        cur_r = 11;
        repeat (5) tick(DAT, 0);
        tick(COM, 0);
        tick(SKP, 0); chk("lit_del_pre_rst", 32'(del_seen), 0);
        rst_n = 1'b0;
        tick(SKP, 0);
        chk("lit_mid_rst_occ", 32'(ebi.occupancy), 0);
        chk("lit_mid_rst_cnt", 32'(ebi.delete_count), 0);
        chk("lit_mid_rst_high", 32'(ebi.high_flag), 0);
        rst_n = 1'b1;
        cur_r = 5;
        repeat (6) tick(DAT, 0);
        chk("lit_post_rst_high", 32'(ebi.high_flag), 1);
        tick(SKP, 0); chk("lit_del_post_rst", 32'(del_seen), 0);

        // full and wrapped pointers
        cur_w = 16; cur_r = 0;
        repeat (5) tick(DAT, 0);
        chk("lit_occ_full", 32'(ebi.occupancy), 16);
        cur_w = 19; cur_r = 4;
        repeat (5) tick(DAT, 0);
        chk("lit_occ_wrap", 32'(ebi.occupancy), 15);

        // saturation of the deletion counter
        repeat (258) tick(DAT, 1);
        tick(DAT, 0);
        chk("lit_cnt_sat", 32'(ebi.delete_count), 255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
